// File: rtl/os_inst_sequencer_pkg.sv
// Shared definitions for the OS instruction sequencer: core inst field map, FSM states, idle word.
package os_inst_sequencer_pkg;

    localparam int INST_W = 36;
    localparam int ADDR_W = 11;

    localparam int INST_OUTEN     = 35;
    localparam int INST_MODE      = 34;
    localparam int INST_ACC       = 33;
    localparam int INST_CEN_PMEM  = 32;
    localparam int INST_WEN_PMEM  = 31;
    localparam int INST_APMEM_LSB = 20;
    localparam int INST_CEN_XMEM  = 19;
    localparam int INST_WEN_XMEM  = 18;
    localparam int INST_AXMEM_LSB = 7;
    localparam int INST_OFIFO_RD  = 6;
    localparam int INST_IFIFO_WR  = 5;
    localparam int INST_IFIFO_RD  = 4;
    localparam int INST_L0_RD     = 3;
    localparam int INST_L0_WR     = 2;
    localparam int INST_EXEC      = 1;
    localparam int INST_LOAD      = 0;

    localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << INST_MODE)
                                            | (INST_W'(1) << INST_CEN_PMEM)
                                            | (INST_W'(1) << INST_WEN_PMEM)
                                            | (INST_W'(1) << INST_CEN_XMEM)
                                            | (INST_W'(1) << INST_WEN_XMEM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_FILL,
        S_X_FILL,
        S_EXEC,
        S_GAP,
        S_DRAIN,
        S_OFIFO_RD,
        S_DONE
    } seq_state_t;

    // Per-channel base address; wraps modulo 2^ADDR_W by construction.
    function automatic logic [ADDR_W-1:0] chan_base(input logic [ADDR_W-1:0] base,
                                                    input int ic, input int len);
        return base + ADDR_W'(ic * len);
    endfunction

endpackage

// File: rtl/os_inst_sequencer_if.sv
// Host-side handshake bundle for os_inst_sequencer.
// SEQ_PERF_CNT_EN adds the perf_cycles/perf_stalls counters.
interface os_inst_sequencer_if #(
    parameter int MAX_IC = 16
);
    localparam int NIC_W = $clog2(MAX_IC + 1);
    localparam int IC_W  = (MAX_IC > 1) ? $clog2(MAX_IC) : 1;

    logic             start;
    logic [NIC_W-1:0] cfg_num_ic;
    logic             cfg_mode;
    logic             ofifo_valid;
    logic [35:0]      inst;
    logic             busy;
    logic             done;
    logic [IC_W-1:0]  cur_ic;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0]      perf_cycles;
    logic [15:0]      perf_stalls;

    modport master (output start, cfg_num_ic, cfg_mode, ofifo_valid,
                    input  inst, busy, done, cur_ic, perf_cycles, perf_stalls);
    modport slave  (input  start, cfg_num_ic, cfg_mode, ofifo_valid,
                    output inst, busy, done, cur_ic, perf_cycles, perf_stalls);
`else
    modport master (output start, cfg_num_ic, cfg_mode, ofifo_valid,
                    input  inst, busy, done, cur_ic);
    modport slave  (input  start, cfg_num_ic, cfg_mode, ofifo_valid,
                    output inst, busy, done, cur_ic);
`endif

endinterface

// File: rtl/os_inst_sequencer_addr_gen.sv
// seq_addr_gen: base + offset address stream with clear, enable and terminal count.
module seq_addr_gen
    import os_inst_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  last_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign addr_o = base_i + ADDR_W'(cnt_q);
    assign tc_o   = (cnt_q == last_i);

endmodule

// File: rtl/os_inst_sequencer.sv
// Output-stationary instruction sequencer: drives the 36-bit core inst word for a multi-channel run.
// Optional SEQ_PERF_CNT_EN adds busy-cycle and OFIFO stall counters.
module os_inst_sequencer
    import os_inst_sequencer_pkg::*;
#(
    parameter int                ROW       = 8,
    parameter int                COL       = 8,
    parameter int                MAX_IC    = 16,
    parameter int                LEN_X     = 9,
    parameter int                LEN_W     = 9,
    parameter int                LEN_ONIJ  = 8,
    parameter logic [ADDR_W-1:0] X_BASE    = 11'h000,
    parameter logic [ADDR_W-1:0] W_BASE    = 11'h400,
    parameter logic [ADDR_W-1:0] P_BASE    = 11'h000,
    parameter int                GAP_CYC   = 16,
    parameter int                DRAIN_CYC = 32
) (
    input  logic               clk,
    input  logic               reset,
    os_inst_sequencer_if.slave bus
);
    localparam int NIC_W      = $clog2(MAX_IC + 1);
    localparam int IC_W       = (MAX_IC > 1) ? $clog2(MAX_IC) : 1;
    localparam int FILL_MAX   = (LEN_W > LEN_X) ? LEN_W : LEN_X;
    localparam int FC_W       = $clog2(FILL_MAX + 1);
    localparam int PC_W       = $clog2(LEN_ONIJ + 1);
    localparam int PH_MAX0    = (GAP_CYC > DRAIN_CYC) ? GAP_CYC : DRAIN_CYC;
    localparam int PH_MAX     = (LEN_X > PH_MAX0) ? LEN_X : PH_MAX0;
    localparam int PH_W       = $clog2(PH_MAX + 1);
    localparam int EXEC_IFIFO = (LEN_W < LEN_X) ? LEN_W : LEN_X;

    if (ROW < 1 || COL < 1 || LEN_X < 1 || LEN_W < 1 || LEN_ONIJ < 1) begin : g_bad_cfg
        $error("os_inst_sequencer: array and stream lengths must be non-zero");
    end

    seq_state_t        state_q, state_d;
    logic [NIC_W-1:0]  ic_q, ic_d, num_ic_q, num_ic_d, num_ic_clamp;
    logic              mode_q, mode_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              xrd_q, xrd_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, done_q;
    logic [IC_W-1:0]   cur_ic_q;
    logic              state_chg, start_acc, fill, counting;
    logic [ADDR_W-1:0] x_base, x_addr, p_addr;
    logic [FC_W-1:0]   x_last;
    logic              x_tc, p_tc;

    assign fill         = (state_q == S_W_FILL) || (state_q == S_X_FILL);
    assign counting     = (state_q == S_EXEC) || (state_q == S_GAP) || (state_q == S_DRAIN);
    assign state_chg    = (state_d != state_q);
    assign num_ic_clamp = (bus.cfg_num_ic > NIC_W'(MAX_IC)) ? NIC_W'(MAX_IC) : bus.cfg_num_ic;
    assign x_base       = (state_q == S_W_FILL) ? chan_base(W_BASE, int'(ic_q), LEN_W)
                                                : chan_base(X_BASE, int'(ic_q), LEN_X);
    assign x_last       = (state_q == S_W_FILL) ? FC_W'(LEN_W) : FC_W'(LEN_X);

    seq_addr_gen #(.CNT_W(FC_W)) u_xmem_addr (
        .clk    (clk),
        .reset  (reset),
        .base_i (x_base),
        .clr_i  (state_chg),
        .en_i   (fill),
        .last_i (x_last),
        .addr_o (x_addr),
        .tc_o   (x_tc)
    );

    seq_addr_gen #(.CNT_W(PC_W)) u_pmem_addr (
        .clk    (clk),
        .reset  (reset),
        .base_i (P_BASE),
        .clr_i  (state_chg),
        .en_i   ((state_q == S_OFIFO_RD) && bus.ofifo_valid),
        .last_i (PC_W'(LEN_ONIJ - 1)),
        .addr_o (p_addr),
        .tc_o   (p_tc)
    );

    // Fill write strobes trail the xmem read by one cycle (SRAM read latency).
    assign xrd_d   = fill && !x_tc;
    assign phase_d = (state_chg || !counting) ? '0 : phase_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ic_d      = ic_q;
        num_ic_d  = num_ic_q;
        mode_d    = mode_q;
        start_acc = 1'b0;
        inst_d    = INST_IDLE;
        if (state_q != S_IDLE && state_q != S_DONE)
            inst_d[INST_MODE] = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    num_ic_d  = num_ic_clamp;
                    mode_d    = bus.cfg_mode;
                    ic_d      = '0;
                    state_d   = (num_ic_clamp == '0) ? S_DONE : S_W_FILL;
                end
            end
            S_W_FILL, S_X_FILL: begin
                inst_d[INST_CEN_XMEM] = x_tc;
                if (!x_tc)
                    inst_d[INST_AXMEM_LSB +: ADDR_W] = x_addr;
                if (state_q == S_W_FILL) begin
                    inst_d[INST_IFIFO_WR] = xrd_q;
                    if (x_tc) state_d = S_X_FILL;
                end else begin
                    inst_d[INST_L0_WR] = xrd_q;
                    if (x_tc) state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_d[INST_EXEC]     = 1'b1;
                inst_d[INST_L0_RD]    = 1'b1;
                inst_d[INST_IFIFO_RD] = (phase_q < PH_W'(EXEC_IFIFO));
                if (phase_q == PH_W'(LEN_X - 1))
                    state_d = S_GAP;
            end
            S_GAP: begin
                if (phase_q == PH_W'(GAP_CYC - 1)) begin
                    if (ic_q == num_ic_q - 1'b1) begin
                        state_d = S_DRAIN;
                    end else begin
                        ic_d    = ic_q + 1'b1;
                        state_d = S_W_FILL;
                    end
                end
            end
            S_DRAIN: begin
                inst_d[INST_OUTEN] = 1'b1;
                if (phase_q == PH_W'(DRAIN_CYC - 1))
                    state_d = S_OFIFO_RD;
            end
            S_OFIFO_RD: begin
                inst_d[INST_APMEM_LSB +: ADDR_W] = p_addr;
                if (bus.ofifo_valid) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    inst_d[INST_CEN_PMEM] = 1'b0;
                    inst_d[INST_WEN_PMEM] = 1'b0;
                    if (p_tc) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ic_q     <= '0;
            num_ic_q <= '0;
            mode_q   <= 1'b1;
            phase_q  <= '0;
            xrd_q    <= 1'b0;
            inst_q   <= INST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cur_ic_q <= '0;
        end else begin
            state_q  <= state_d;
            ic_q     <= ic_d;
            num_ic_q <= num_ic_d;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            xrd_q    <= xrd_d;
            inst_q   <= inst_d;
            busy_q   <= (state_q != S_IDLE) && (state_q != S_DONE);
            done_q   <= (state_q == S_DONE);
            cur_ic_q <= ic_q[IC_W-1:0];
        end
    end

    assign bus.inst   = inst_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cur_ic = cur_ic_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cyc_q;
    logic [15:0] perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cyc_q   <= '0;
            perf_stall_q <= '0;
        end else if (start_acc) begin
            perf_cyc_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_q && perf_cyc_q != '1)
                perf_cyc_q <= perf_cyc_q + 1'b1;
            if (state_q == S_OFIFO_RD && !bus.ofifo_valid && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign bus.perf_cycles = perf_cyc_q;
    assign bus.perf_stalls = perf_stall_q;
`endif

endmodule
